// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, data width, default bit timing.
// Latency: n/a (declarations only). Backpressure: n/a.
// PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
// Latency: 2 clk cycles. Backpressure: none, free-running.
// Used on the serial line so metastability never reaches the FSM.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, or 8E1 with even parity when UART_RX_PARITY_EN is defined.
// Latency: strobes one clk after the mid-stop-bit sample (+2 clk input synchronizer).
// Backpressure: none; rx_valid is a one-cycle strobe and the consumer must take it.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
    logic                 bit_done;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign bit_done = (cnt == CNT_END);
    assign busy     = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_nxt;
    logic perr_q, perr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            par_bit <= par_nxt;
            perr_q  <= perr_nxt;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = rx_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt == CNT_MID) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = rx_s;
                    idx_nxt        = idx + IW'(1);
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_nxt   = '0;
                    par_nxt   = rx_s;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end else begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg, par_bit}) begin
                            perr_nxt = 1'b1;
                        end else begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                        end
`else
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low break must not retrigger; wait for the line to go idle.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
